// File: rtl/mem_arbiter_rr_if.sv
// Request/RAM bundle between the per-CPU ports, the arbiter and the single RAM port.
// The slave view is the arbiter's side; the master view is the environment (CPUs and RAM).
interface mem_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic [1:0]             ramstate;
    logic [WORD_W-1:0]      ramload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin RAM arbiter: data requests beat instruction requests, one locked grant
// per RAM transaction, separate fairness pointers per class.
//
// state | meaning
// IDLE  | no grant; RAM enables low; picks the next winner
// GRANT | owner/kind drive the RAM until ACCESS (done) or the request drops (abort)
module mem_arbiter_rr #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    mem_arbiter_rr_if.slave  bus
);
    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    typedef enum logic {DATA = 1'b0, INSTR = 1'b1} kind_t;

    state_t          state, state_nx;
    kind_t           kind, kind_nx;
    logic [OW-1:0]   owner, owner_nx;
    logic [OW-1:0]   dptr, dptr_nx;
    logic [OW-1:0]   iptr, iptr_nx;
    logic [CPUS-1:0] dreq;
    logic [OW-1:0]   d_win, i_win;
    logic            active;
    logic            done;

    // First set bit of req at or after ptr, wrapping modulo CPUS (any CPUS, not just 2^n).
    function automatic logic [OW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [OW-1:0] ptr);
        logic [OW-1:0] win;
        logic [OW-1:0] idx;
        logic          hit;
        int            j;
        win = '0;
        hit = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            j = int'(ptr) + i;
            if (j >= CPUS) j = j - CPUS;
            idx = OW'(j);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        return win;
    endfunction

    function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] k);
        if (k == OW'(CPUS - 1)) return '0;
        return k + OW'(1);
    endfunction

    assign dreq   = bus.dREN | bus.dWEN;
    assign d_win  = rr_pick(dreq, dptr);
    assign i_win  = rr_pick(bus.iREN, iptr);
    assign active = (state == GRANT) && ((kind == DATA) ? dreq[owner] : bus.iREN[owner]);
    assign done   = active && (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            kind  <= DATA;
            owner <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            owner <= owner_nx;
            dptr  <= dptr_nx;
            iptr  <= iptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        owner_nx = owner;
        dptr_nx  = dptr;
        iptr_nx  = iptr;

        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (|dreq) begin
                    state_nx = GRANT;
                    owner_nx = d_win;
                    kind_nx  = DATA;
                end else if (|bus.iREN) begin
                    state_nx = GRANT;
                    owner_nx = i_win;
                    kind_nx  = INSTR;
                end
            end
            GRANT: begin
                if (done) begin
                    state_nx = IDLE;
                    if (kind == DATA) dptr_nx = ptr_after(owner);
                    else              iptr_nx = ptr_after(owner);
                end else if (!active) begin
                    // abandoned request: release without advancing fairness
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (active) begin
            if (kind == DATA) begin
                bus.ramaddr = bus.daddr[owner*WORD_W +: WORD_W];
                if (bus.dWEN[owner]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore[owner*WORD_W +: WORD_W];
                end else begin
                    bus.ramREN = 1'b1;
                end
                if (done) begin
                    bus.dwait[owner]                     = 1'b0;
                    bus.dload[owner*WORD_W +: WORD_W]    = bus.ramload;
                end
            end else begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[owner*WORD_W +: WORD_W];
                if (done) begin
                    bus.iwait[owner]                     = 1'b0;
                    bus.iload[owner*WORD_W +: WORD_W]    = bus.ramload;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr with three cores: table of single transactions, then
// hand sequences for priority, fairness, abort and reset-mid-grant.
module tb_mem_arbiter_rr;
    localparam int CPUS = 3;
    localparam int W    = 32;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_rr_if #(.CPUS(CPUS), .WORD_W(W)) bus ();
    mem_arbiter_rr #(.CPUS(CPUS), .WORD_W(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    // RAM model: ACCESS once the enable has been held ram_lat cycles, unless forced BUSY/ERROR.
    int         ram_lat;
    logic [1:0] ram_mode;
    logic [W-1:0] ram_rdata;
    int         ram_cnt;
    logic       ram_en;
    assign ram_en = bus.ramREN | bus.ramWEN;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)       ram_cnt <= 0;
        else if (ram_en) ram_cnt <= ram_cnt + 1;
        else             ram_cnt <= 0;
    end
    assign bus.ramstate = !ram_en ? R_FREE :
                          (ram_mode == 2'd1) ? R_BUSY :
                          (ram_mode == 2'd2) ? R_ERROR :
                          (ram_cnt >= ram_lat) ? R_ACCESS : R_BUSY;
    assign bus.ramload = ram_rdata;

    typedef struct {
        int       cpu;
        bit       is_data;
        bit       ren;
        bit       wen;
        logic [W-1:0] addr;
        logic [W-1:0] store;
        logic [W-1:0] load;
    } exp_t;

    typedef struct {
        bit       is_data;
        int       cpu;
        bit       rd;
        bit       wr;
        logic [W-1:0] addr;
        logic [W-1:0] store;
        int       lat;
        logic [W-1:0] rdata;
        bit       exp_ren;
        bit       exp_wen;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    logic [W-1:0] ia[CPUS];
    logic [W-1:0] da[CPUS];
    logic [W-1:0] ds[CPUS];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_addrs();
        for (int k = 0; k < CPUS; k++) begin
            bus.iaddr[k*W +: W]  = ia[k];
            bus.daddr[k*W +: W]  = da[k];
            bus.dstore[k*W +: W] = ds[k];
        end
    endtask

    task automatic expect_txn(input int cpu, input bit is_data, input bit ren, input bit wen,
                              input logic [W-1:0] addr, input logic [W-1:0] store);
        exp_t e;
        e.cpu = cpu; e.is_data = is_data; e.ren = ren; e.wen = wen;
        e.addr = addr; e.store = store; e.load = ram_rdata;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs();
        check("rst_iwait", bus.iwait, 3'b111);
        check("rst_dwait", bus.dwait, 3'b111);
        check("rst_iload", |bus.iload, 1'b0);
        check("rst_dload", |bus.dload, 1'b0);
        check("rst_ram_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_ramstore", bus.ramstore, 0);
    endtask

    // Called at a negedge: checks the one-hot wait rule and pops the scoreboard on completion.
    task automatic observe(output logic [CPUS-1:0] idone, output logic [CPUS-1:0] ddone);
        exp_t e;
        int n, cpu;
        bit is_d, stray;
        logic [W-1:0] ld;
        idone = ~bus.iwait;
        ddone = ~bus.dwait;
        n = $countones({idone, ddone});
        check("one_wait_low", n <= 1, 1'b1);
        check("done_without_enable", (n != 0) && !ram_en, 1'b0);
        stray = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            if (bus.iwait[k] && bus.iload[k*W +: W] != '0) stray = 1'b1;
            if (bus.dwait[k] && bus.dload[k*W +: W] != '0) stray = 1'b1;
        end
        check("waiting_load_zero", stray, 1'b0);
        if (n == 1) begin
            cpu = 0;
            is_d = 1'b0;
            for (int k = 0; k < CPUS; k++) begin
                if (idone[k]) cpu = k;
                if (ddone[k]) begin cpu = k; is_d = 1'b1; end
            end
            ld = is_d ? bus.dload[cpu*W +: W] : bus.iload[cpu*W +: W];
            check("expected_completion", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("grant_cpu", cpu, e.cpu);
                check("grant_kind", is_d, e.is_data);
                check("ram_ctl", {bus.ramREN, bus.ramWEN}, {e.ren, e.wen});
                check("ram_addr", bus.ramaddr, e.addr);
                if (e.wen) check("ram_store", bus.ramstore, e.store);
                check("load", ld, e.load);
            end
        end
    endtask

    task automatic run_cycles(input int max_cyc, input bit auto_drop, input int want,
                              output int done_c, output int en_c);
        int got;
        logic [CPUS-1:0] idn, ddn;
        got = 0;
        done_c = -1;
        en_c = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (en_c < 0 && ram_en) en_c = c;
            observe(idn, ddn);
            if ((|idn) || (|ddn)) begin
                got++;
                if (done_c < 0) done_c = c;
            end
            @(posedge CLK);
            #1;
            if (auto_drop) begin
                bus.iREN = bus.iREN & ~idn;
                bus.dREN = bus.dREN & ~ddn;
                bus.dWEN = bus.dWEN & ~ddn;
            end
            if (got >= want) break;
        end
        check("completions", got, want);
    endtask

    task automatic wait_grant(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (ram_en) begin seen = 1'b1; break; end
        end
        check("grant_seen", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int dc, ec;

        vecs[0] = '{1'b0, 0, 1'b0, 1'b0, 32'h40,  32'h0,        2, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2, 1'b1, 1'b0, 32'h100, 32'h0,        0, 32'h11112222, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 0, 1'b1, 1'b1, 32'h200, 32'h1234,     1, 32'h33334444, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 3, 32'h55556666, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 2, 1'b0, 1'b1, 32'h400, 32'h0BADF00D, 2, 32'h77778888, 1'b0, 1'b1};

        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        for (int k = 0; k < CPUS; k++) begin
            ia[k] = 32'h2000 + 32'(k * 4);
            da[k] = 32'h1000 + 32'(k * 16);
            ds[k] = 32'hD000_0000 + 32'(k);
        end
        drive_addrs();
        ram_mode = 2'd0; ram_lat = 1; ram_rdata = '0;

        #12;
        check_reset_outputs();
        @(posedge CLK); #1;
        nRST = 1'b1;

        // single transactions; pointers afterwards: iptr=1, dptr=0
        for (int t = 0; t < 5; t++) begin
            v = vecs[t];
            @(posedge CLK); #1;
            ram_lat = v.lat; ram_rdata = v.rdata; ram_mode = 2'd0;
            if (v.is_data) begin da[v.cpu] = v.addr; ds[v.cpu] = v.store; end
            else ia[v.cpu] = v.addr;
            drive_addrs();
            expect_txn(v.cpu, v.is_data, v.exp_ren, v.exp_wen, v.addr, v.store);
            if (v.is_data) begin bus.dREN[v.cpu] = v.rd; bus.dWEN[v.cpu] = v.wr; end
            else bus.iREN[v.cpu] = 1'b1;
            run_cycles(30, 1'b1, 1, dc, ec);
            check("lat_enable_cycle", ec, 1);
            check("lat_done_cycle", dc, 1 + v.lat);
        end

        // all cores fetch: iptr=1 after the first fetch, so order 1,2,0 (wrap at 3)
        @(posedge CLK); #1;
        for (int k = 0; k < CPUS; k++) ia[k] = 32'h2000 + 32'(k * 4);
        drive_addrs();
        ram_lat = 1; ram_rdata = 32'hA1A1_0001;
        expect_txn(1, 1'b0, 1'b1, 1'b0, ia[1], 0);
        expect_txn(2, 1'b0, 1'b1, 1'b0, ia[2], 0);
        expect_txn(0, 1'b0, 1'b1, 1'b0, ia[0], 0);
        bus.iREN = '1;
        run_cycles(40, 1'b1, 3, dc, ec);

        // data beats instruction raised in the same cycle
        @(posedge CLK); #1;
        da[1] = 32'h1010; drive_addrs();
        ram_rdata = 32'hB2B2_0002;
        expect_txn(1, 1'b1, 1'b1, 1'b0, da[1], 0);
        expect_txn(0, 1'b0, 1'b1, 1'b0, ia[0], 0);
        bus.iREN[0] = 1'b1;
        bus.dREN[1] = 1'b1;
        run_cycles(40, 1'b1, 2, dc, ec);

        // abort under BUSY/ERROR; iptr stays 1, dptr goes 2 -> 1 via the data grant to CPU0
        @(posedge CLK); #1;
        ram_mode = 2'd1;
        ia[1] = 32'h2104; da[0] = 32'h1000; drive_addrs();
        bus.iREN[1] = 1'b1;
        wait_grant(10);
        check("abort_pre_addr", bus.ramaddr, ia[1]);
        @(posedge CLK); #1;
        ram_mode = 2'd2;
        @(negedge CLK);
        check("error_hold_ren", bus.ramREN, 1'b1);
        check("error_hold_iwait", bus.iwait, 3'b111);
        @(posedge CLK); #1;
        ram_mode = 2'd1;
        bus.iREN[1] = 1'b0;
        bus.dREN[0] = 1'b1;
        #1;
        check("abort_ren_drop", bus.ramREN, 1'b0);
        check("abort_iwait", bus.iwait[1], 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        check("abort_idle", ram_en, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check("abort_regrant_ctl", {bus.ramREN, bus.ramWEN}, 2'b10);
        check("abort_regrant_addr", bus.ramaddr, da[0]);
        @(posedge CLK); #1;
        ram_rdata = 32'hC3C3_0003;
        expect_txn(0, 1'b1, 1'b1, 1'b0, da[0], 0);
        ram_mode = 2'd0; ram_lat = 0;
        run_cycles(10, 1'b1, 1, dc, ec);

        @(posedge CLK); #1;
        ram_lat = 1;
        expect_txn(1, 1'b0, 1'b1, 1'b0, ia[1], 0);
        expect_txn(2, 1'b0, 1'b1, 1'b0, ia[2], 0);
        expect_txn(0, 1'b0, 1'b1, 1'b0, ia[0], 0);
        bus.iREN = '1;
        run_cycles(40, 1'b1, 3, dc, ec);

        // reset mid-grant (dptr=1 beforehand), then fairness must restart at CPU0
        @(posedge CLK); #1;
        ram_mode = 2'd1;
        for (int k = 0; k < CPUS; k++) begin
            da[k] = 32'h3000 + 32'(k * 16);
            ds[k] = 32'hE000_0000 + 32'(k * 3 + 1);
        end
        drive_addrs();
        bus.dWEN[1] = 1'b1;
        wait_grant(10);
        check("pre_rst_wen", bus.ramWEN, 1'b1);
        check("pre_rst_addr", bus.ramaddr, da[1]);
        #2;
        nRST = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge CLK); #1;
        bus.dWEN = '1;
        ram_mode = 2'd0; ram_lat = 1; ram_rdata = 32'hD4D4_0004;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < CPUS; k++)
                expect_txn(k, 1'b1, 1'b0, 1'b1, da[k], ds[k]);
        @(posedge CLK); #1;
        nRST = 1'b1;
        run_cycles(60, 1'b0, 6, dc, ec);
        bus.dWEN = '0;

        run_cycles(5, 1'b1, 0, dc, ec);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
